// File: rtl/reduce_xor_pkg.sv
// Shared sizing helpers for the XOR reduction pipeline.
// Provides tree-level and stage-count arithmetic used by the top and stage
// modules, plus the default element type.
package reduce_xor_pkg;

  localparam int unsigned DEFAULT_ELEMENT_WIDTH = 4;

  typedef logic [DEFAULT_ELEMENT_WIDTH-1:0] element_t;

  // Depth of the full pairwise XOR tree for n elements.
  function automatic int unsigned tree_levels(input int unsigned n);
    return (n <= 1) ? 32'd0 : 32'($clog2(n));
  endfunction

  // Number of registered stages when sl tree levels share one stage (at least one).
  function automatic int unsigned stage_count(input int unsigned n, input int unsigned sl);
    int unsigned l;
    int unsigned s;
    l = tree_levels(n);
    s = (l + sl - 1) / sl;
    return (s == 0) ? 32'd1 : s;
  endfunction

  // Element count remaining after lv pairwise levels.
  function automatic int unsigned elems_after(input int unsigned n, input int unsigned lv);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < lv; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/reduce_xor_pipe_if.sv
// Beat-in / result-out handshake bundle for reduce_xor_pipe.
// master: producer of beats and consumer of results (bench / upstream logic).
// slave : the reduction pipeline.
interface reduce_xor_pipe_if #(
  parameter int unsigned NUM_ELEMENTS  = 5,
  parameter int unsigned ELEMENT_WIDTH = 4
);
  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] in_elements;
  logic                                  in_valid;
  logic                                  in_ready;
  logic                                  in_last;
  logic [ELEMENT_WIDTH-1:0]              out_xor;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (
    output in_elements, in_valid, in_last, out_ready,
    input  in_ready, out_xor, out_valid
  );

  modport slave (
    input  in_elements, in_valid, in_last, out_ready,
    output in_ready, out_xor, out_valid
  );
endinterface

// File: rtl/reduce_xor_stage.sv
// One registered slice of the XOR tree: LEVELS pairwise levels followed by a
// valid/data/last register that loads whenever load is high.
// Ports: clk, rst_n (async active-low), load, in_data/in_valid/in_last from
// the previous slice, out_data/out_valid/out_last registered.
// With ACCUM set (final slice only) results are XOR-accumulated across a
// frame and out_valid rises only for the frame's last beat.
module reduce_xor_stage import reduce_xor_pkg::*; #(
  parameter int unsigned IN_CNT        = 2,
  parameter int unsigned LEVELS        = 1,
  parameter int unsigned ELEMENT_WIDTH = 4,
  parameter bit          ACCUM         = 1'b0,
  localparam int unsigned OUT_CNT      = elems_after(IN_CNT, LEVELS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load,
  input  logic [IN_CNT*ELEMENT_WIDTH-1:0]   in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic [OUT_CNT*ELEMENT_WIDTH-1:0]  out_data,
  output logic                              out_valid,
  output logic                              out_last
);

  localparam int unsigned W  = ELEMENT_WIDTH;
  localparam int unsigned DW = OUT_CNT * W;

  // Pairwise XOR levels; the zero padding makes an odd element pass through.
  function automatic logic [DW-1:0] reduce_levels(input logic [IN_CNT*W-1:0] d);
    logic [2*IN_CNT*W-1:0] cur;
    logic [2*IN_CNT*W-1:0] nxt;
    cur = '0;
    cur[IN_CNT*W-1:0] = d;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      nxt = '0;
      for (int unsigned i = 0; i < IN_CNT; i++)
        nxt[i*W +: W] = cur[2*i*W +: W] ^ cur[(2*i+1)*W +: W];
      cur = nxt;
    end
    return cur[DW-1:0];
  endfunction

  logic [DW-1:0] tree;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          last_q;

  assign tree      = reduce_levels(in_data);
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

  if (ACCUM) begin : g_accum
    logic [W-1:0] acc;

    // Non-last beats fold into acc and leave the slice empty; the last beat
    // presents the frame total and restarts the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
        acc     <= '0;
      end else if (load) begin
        valid_q <= in_valid && in_last;
        last_q  <= in_valid && in_last;
        if (in_valid) begin
          if (in_last) begin
            data_q <= DW'(acc ^ tree[W-1:0]);
            acc    <= '0;
          end else begin
            acc    <= acc ^ tree[W-1:0];
          end
        end
      end
    end
  end else begin : g_plain
    // Plain pipeline register; data holds while empty or stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
      end else if (load) begin
        valid_q <= in_valid;
        last_q  <= in_last;
        if (in_valid) data_q <= tree;
      end
    end
  end

endmodule

// File: rtl/reduce_xor_pipe.sv
// Pipelined XOR reduction of NUM_ELEMENTS elements per beat with
// valid/ready flow control and bubble collapsing.
// Ports: in_clock, in_reset_n (async active-low), bus (slave modport):
//   in_elements/in_valid/in_last/in_ready beat side,
//   out_xor/out_valid/out_ready result side.
// Define REDUCE_XOR_PIPE_ACCUM_EN to accumulate beats into one result per
// frame (frame ends at in_last); otherwise in_last is carried but ignored.
module reduce_xor_pipe import reduce_xor_pkg::*; #(
  parameter int unsigned NUM_ELEMENTS  = 5,
  parameter int unsigned ELEMENT_WIDTH = 4,
  parameter int unsigned STAGE_LEVELS  = 1
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  reduce_xor_pipe_if.slave   bus
);

  localparam int unsigned NUM_STAGES = stage_count(NUM_ELEMENTS, STAGE_LEVELS);
  localparam int unsigned EW         = ELEMENT_WIDTH;

`ifdef REDUCE_XOR_PIPE_ACCUM_EN
  localparam bit ACCUM_EN = 1'b1;
`else
  localparam bit ACCUM_EN = 1'b0;
`endif

  logic [NUM_STAGES-1:0] vld;
  logic [NUM_STAGES-1:0] ld;
  logic                  unused_tail_last;

  // A slice loads when it is empty or its successor is taking its contents.
  always_comb begin
    ld = '0;
    ld[NUM_STAGES-1] = !vld[NUM_STAGES-1] || bus.out_ready;
    for (int k = int'(NUM_STAGES) - 2; k >= 0; k--)
      ld[k] = !vld[k] || ld[k+1];
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int unsigned IN_CNT  = elems_after(NUM_ELEMENTS, 32'(k) * STAGE_LEVELS);
    localparam int unsigned OUT_CNT = elems_after(NUM_ELEMENTS, 32'(k + 1) * STAGE_LEVELS);

    logic [IN_CNT*EW-1:0]  din;
    logic                  din_valid;
    logic                  din_last;
    logic [OUT_CNT*EW-1:0] dout;
    logic                  dout_last;

    if (k == 0) begin : g_head
      assign din       = bus.in_elements;
      assign din_valid = bus.in_valid;
      assign din_last  = bus.in_last;
    end else begin : g_link
      assign din       = g_stage[k-1].dout;
      assign din_valid = vld[k-1];
      assign din_last  = g_stage[k-1].dout_last;
    end

    reduce_xor_stage #(
      .IN_CNT        (IN_CNT),
      .LEVELS        (STAGE_LEVELS),
      .ELEMENT_WIDTH (EW),
      .ACCUM         (ACCUM_EN && (k == NUM_STAGES - 1))
    ) u_stage (
      .clk       (in_clock),
      .rst_n     (in_reset_n),
      .load      (ld[k]),
      .in_data   (din),
      .in_valid  (din_valid),
      .in_last   (din_last),
      .out_data  (dout),
      .out_valid (vld[k]),
      .out_last  (dout_last)
    );
  end

  // Ready is forced low during reset so no beat is offered a handshake then.
  assign bus.in_ready  = in_reset_n && ld[0];
  assign bus.out_valid = vld[NUM_STAGES-1];
  assign bus.out_xor   = g_stage[NUM_STAGES-1].dout;
  assign unused_tail_last = g_stage[NUM_STAGES-1].dout_last;

endmodule

// File: tb/tb_reduce_xor_pipe.sv
// Directed bench for reduce_xor_pipe: main instance N=5/W=4/SL=1 (3 stages),
// plus N=1/SL=2 (1 stage) and N=8/SL=2 (2 stages) instances.
module tb_reduce_xor_pipe;

`ifdef REDUCE_XOR_PIPE_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  reduce_xor_pipe_if #(.NUM_ELEMENTS(5), .ELEMENT_WIDTH(4)) bus_a ();
  reduce_xor_pipe_if #(.NUM_ELEMENTS(1), .ELEMENT_WIDTH(4)) bus_b ();
  reduce_xor_pipe_if #(.NUM_ELEMENTS(8), .ELEMENT_WIDTH(4)) bus_c ();

  reduce_xor_pipe #(.NUM_ELEMENTS(5), .ELEMENT_WIDTH(4), .STAGE_LEVELS(1)) dut_a (
    .in_clock(clk), .in_reset_n(rst_n), .bus(bus_a));
  reduce_xor_pipe #(.NUM_ELEMENTS(1), .ELEMENT_WIDTH(4), .STAGE_LEVELS(2)) dut_b (
    .in_clock(clk), .in_reset_n(rst_n), .bus(bus_b));
  reduce_xor_pipe #(.NUM_ELEMENTS(8), .ELEMENT_WIDTH(4), .STAGE_LEVELS(2)) dut_c (
    .in_clock(clk), .in_reset_n(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] red8(input logic [31:0] v);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 8; i++) r ^= v[i*4 +: 4];
    return r;
  endfunction

  logic [19:0] beats33 [4];
  logic [3:0]  exp33   [3];
  logic        rdy33   [5];
  logic [19:0] beats35 [4];
  logic        last35  [4];
  logic        v_b [32];
  logic [3:0]  e_b [32];
  logic        v_c [32];
  logic [31:0] e_c [32];
  int          idx;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus_a.in_elements = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_elements = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b1; bus_b.out_ready = 1'b1;
    bus_c.in_elements = '0; bus_c.in_valid = 1'b0; bus_c.in_last = 1'b1; bus_c.out_ready = 1'b1;
    repeat (2) step();

    // Reset state
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_out_xor",   32'(bus_a.out_xor),   32'd0);
    check("rst_in_ready",  32'(bus_a.in_ready),  32'd0);
    check("rst_in_ready_c", 32'(bus_c.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus_a.in_ready), 32'd1);
    step();

    // Single beat {1,2,4,8,3} -> 0xC after 3 cycles, for one cycle
    bus_a.in_elements = 20'h38421;
    bus_a.in_valid    = 1'b1;
    bus_a.in_last     = 1'b1;
    #1;
    check("t31_in_ready", 32'(bus_a.in_ready), 32'd1);
    step();
    bus_a.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check("t31_out_valid", 32'(bus_a.out_valid), 32'(c == 3));
      if (c == 3) check("t31_out_xor", 32'(bus_a.out_xor), 32'hC);
      step();
    end

    // Ten back-to-back beats {k,0,0,0,0}
    for (int c = 0; c <= 13; c++) begin
      if (c < 10) begin
        bus_a.in_elements = 20'(c + 1);
        bus_a.in_valid    = 1'b1;
        bus_a.in_last     = ACC;
      end else begin
        bus_a.in_valid = 1'b0;
      end
      #1;
      if (c < 10) check("t32_in_ready", 32'(bus_a.in_ready), 32'd1);
      check("t32_out_valid", 32'(bus_a.out_valid), 32'(c >= 3 && c <= 12));
      if (c >= 3 && c <= 12) check("t32_out_xor", 32'(bus_a.out_xor), 32'(c - 2));
      step();
    end

    // Stall: pipe fills with 3 beats, ready drops, output holds; then drain
    beats33[0] = 20'h00053; beats33[1] = 20'h90000; beats33[2] = 20'h0021F; beats33[3] = 20'h0000A;
    exp33[0] = 4'h6; exp33[1] = 4'h9; exp33[2] = 4'hC;
    rdy33[0] = 1'b1; rdy33[1] = 1'b1; rdy33[2] = 1'b1; rdy33[3] = 1'b0; rdy33[4] = 1'b0;
    bus_a.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c <= 4; c++) begin
      bus_a.in_elements = beats33[idx];
      bus_a.in_valid    = 1'b1;
      bus_a.in_last     = 1'b1;
      #1;
      check("t33_in_ready", 32'(bus_a.in_ready), 32'(rdy33[c]));
      check("t33_out_valid", 32'(bus_a.out_valid), 32'(c >= 3));
      if (c >= 3) check("t33_hold_xor", 32'(bus_a.out_xor), 32'h6);
      if (bus_a.in_ready) idx++;
      step();
    end
    check("t33_accepted", 32'(idx), 32'd3);
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    for (int c = 5; c <= 8; c++) begin
      #1;
      check("t33_drain_valid", 32'(bus_a.out_valid), 32'(c < 8));
      if (c < 8) check("t33_drain_xor", 32'(bus_a.out_xor), 32'(exp33[c-5]));
      step();
    end

    // Reset with two beats in flight
    bus_a.in_elements = 20'h00001; bus_a.in_valid = 1'b1; bus_a.in_last = 1'b1;
    step();
    bus_a.in_elements = 20'h00002;
    step();
    bus_a.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t34_rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("t34_rst_ready", 32'(bus_a.in_ready),  32'd0);
    step();
    step();
    check("t34_rst_xor",   32'(bus_a.out_xor),   32'd0);
    check("t34_rst_valid2", 32'(bus_a.out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("t34_rel_ready", 32'(bus_a.in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t34_no_stale", 32'(bus_a.out_valid), 32'd0);
    end

    // Frame accumulation: {1},{2},{4 last} -> 7, then {8 last} -> 8
    if (ACC) begin
      beats35[0] = 20'h1; beats35[1] = 20'h2; beats35[2] = 20'h4; beats35[3] = 20'h8;
      last35[0] = 1'b0; last35[1] = 1'b0; last35[2] = 1'b1; last35[3] = 1'b1;
      for (int c = 0; c <= 7; c++) begin
        if (c < 4) begin
          bus_a.in_elements = beats35[c];
          bus_a.in_last     = last35[c];
          bus_a.in_valid    = 1'b1;
        end else begin
          bus_a.in_valid = 1'b0;
        end
        #1;
        check("t35_out_valid", 32'(bus_a.out_valid), 32'(c == 5 || c == 6));
        if (c == 5) check("t35_frame0", 32'(bus_a.out_xor), 32'h7);
        if (c == 6) check("t35_frame1", 32'(bus_a.out_xor), 32'h8);
        step();
      end
    end

    // N=1 (1 stage) and N=8/SL=2 (2 stages) against the reference XOR
    for (int c = 0; c < 26; c++) begin
      v_b[c] = (c < 20) && ($urandom_range(0, 3) != 0);
      e_b[c] = 4'($urandom);
      v_c[c] = (c < 20) && ($urandom_range(0, 3) != 0);
      e_c[c] = $urandom;
      bus_b.in_valid = v_b[c]; bus_b.in_elements = e_b[c];
      bus_c.in_valid = v_c[c]; bus_c.in_elements = e_c[c];
      #1;
      check("t36_b_ready", 32'(bus_b.in_ready), 32'd1);
      check("t36_c_ready", 32'(bus_c.in_ready), 32'd1);
      check("t36_b_valid", 32'(bus_b.out_valid), 32'(c >= 1 && v_b[(c >= 1) ? c - 1 : 0]));
      if (c >= 1 && v_b[c-1]) check("t36_b_xor", 32'(bus_b.out_xor), 32'(e_b[c-1]));
      check("t36_c_valid", 32'(bus_c.out_valid), 32'(c >= 2 && v_c[(c >= 2) ? c - 2 : 0]));
      if (c >= 2 && v_c[c-2]) check("t36_c_xor", 32'(bus_c.out_xor), 32'(red8(e_c[c-2])));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reduce_xor_pipe.md
REDUCE_XOR_PIPE -- requirements
Module: reduce_xor_pipe

Interface
REQ-001 Parameter NUM_ELEMENTS, default 5, number of input elements XOR-reduced per beat (>=1).
REQ-002 Parameter ELEMENT_WIDTH, default 4, bit width of each element and of the result.
REQ-003 Parameter STAGE_LEVELS, default 1, tree levels combined between pipeline registers (>=1).
REQ-004 The block SHALL have one clock, in_clock; reset is asynchronous and active-low, in_reset_n.
REQ-005 in_clock  input  1  rising-edge clock.
REQ-006 in_reset_n  input  1  asynchronous active-low reset.
REQ-007 in_elements  input  NUM_ELEMENTS x ELEMENT_WIDTH  packed element array, element i at slice i.
REQ-008 in_valid  input  1  in_elements valid this cycle.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 in_last  input  1  final beat of a frame (used only in accumulate mode).
REQ-011 out_xor  output  ELEMENT_WIDTH  reduction result.
REQ-012 out_valid  output  1  out_xor valid.
REQ-013 out_ready  input  1  downstream accepts out_xor.

Function
REQ-014 Tree depth L = clog2(NUM_ELEMENTS); stage count S = max(1, ceil(L / STAGE_LEVELS)).
REQ-015 Each level pairs elements 2i and 2i+1 by XOR; an unpaired odd element passes through unchanged; missing elements are zero.
REQ-016 Beat transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Each stage holds a valid bit and data; stage k loads when stage k+1 is empty or advancing in the same cycle (last stage: out_ready).
REQ-018 in_ready SHALL equal the load condition of stage 0 (combinational from downstream state and out_ready, never from in_valid).
REQ-019 With out_ready held high, latency is exactly S cycles from accepted beat to out_valid, throughput one beat per cycle.
REQ-020 With out_ready low, out_xor and out_valid SHALL hold stable; the pipeline fills to S beats, then in_ready deasserts; no beat dropped or duplicated.
REQ-021 Bubbles collapse: an empty stage loads even when downstream is stalled.
REQ-022 Beat order is preserved; NUM_ELEMENTS=1 yields out_xor = in_elements[0] after 1 cycle.

Reset
REQ-023 While in_reset_n is low all stage valid bits, out_valid and out_xor SHALL be 0 and in_ready SHALL be 0.
REQ-024 Reset asserted mid-operation discards all in-flight beats and any partial accumulation; the first cycle after release has in_ready=1.

Configuration
REQ-025 Macro REDUCE_XOR_PIPE_ACCUM_EN selects accumulate mode.
REQ-026 Defined: the last stage XORs each arriving result into an accumulator; out_valid asserts only for a beat with in_last (carried through the pipe), presenting the XOR of all frame beats; the accumulator clears on that output transfer; non-last beats retire without asserting out_valid.
REQ-027 Defined: a single-beat frame (in_last on first beat) outputs that beat's reduction; back-to-back frames SHALL not leak accumulation across frames.
REQ-028 Undefined: in_last is ignored and every beat produces one output.

Structure
REQ-029 Package reduce_xor_pkg holds the level-count and stage-count functions (REQ-014) and the element typedef parameterised by ELEMENT_WIDTH.
REQ-030 One sub-module, reduce_xor_stage, implements a single registered stage (STAGE_LEVELS tree levels plus valid/data register and load logic); the top instantiates S of them.

Verification
REQ-031 N=5, W=4, SL=1, out_ready=1: beat {1,2,4,8,3} at cycle 0 -> out_xor=0xC, out_valid at cycle 3 for one cycle.
REQ-032 Continuous beats {k,0,0,0,0}, k=1..10, out_ready=1 -> outputs 1..10 in order on consecutive cycles, in_ready constantly 1.
REQ-033 out_ready=0 while feeding beats -> in_ready drops after 3 accepted beats, out_xor stable; release out_ready -> all 3 emitted in order, none lost.
REQ-034 Reset pulse with 2 beats in flight -> out_valid=0 during and after reset, no stale output emitted, in_ready=1 one cycle after release.
REQ-035 ACCUM_EN: beats {1,0,0,0,0},{2,0,0,0,0},{4,0,0,0,0 last} -> single output 0x7; next frame {8.. last} -> 0x8.
REQ-036 N=1 and N=8 with SL=2: random beats vs reference model -> S=1 and S=2 latencies, results match.
